// File: rtl/ps2_host_cmd_ctrl.sv
// PS/2 host-to-device command scheduler: arbitrates system/LED requests, shifts the
// chosen byte(s) onto the open-drain lines and interprets the device response.
module ps2_host_cmd_ctrl #(
  parameter int unsigned INHIBIT_CYCLES = 2700,
  parameter int unsigned TIMEOUT_CYCLES = 540000,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       ps2ClkOe,
  output logic       ps2DatOe,
  input  logic       sysReq,
  input  logic [7:0] sysCmd,
  input  logic       sysHasArg,
  input  logic [7:0] sysArg,
  input  logic       ledReq,
  input  logic [2:0] ledMask,
  output logic       sysGrant,
  output logic       ledGrant,
  input  logic [7:0] rxByte,
  input  logic       rxValid,
  output logic       rxBlock,
  output logic       busy,
  output logic       cmdDone,
  output logic       cmdError
);

  localparam int unsigned MAX_CNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_TXBIT, S_WAITACK, S_WAITRESP, S_WAITBAT
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         clk_sync, dat_sync;
  logic               clk_prev;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         edge_cnt;
  logic [RETRY_W-1:0] retry;
  logic               sending_arg, has_arg_r;
  logic [7:0]         cmd_r, arg_r;

  logic       fall, dat_s, timeout, inhibit_end, parity_bit;
  logic [3:0] edge_nxt;
  logic [7:0] cur_byte;
  logic       take_sys, take_led, go_arg, go_retry, done_c, err_c;
  logic       clk_oe_d, dat_oe_d, busy_d, block_d;

  assign fall        = clk_prev & ~clk_sync[1];
  assign dat_s       = dat_sync[1];
  assign cur_byte    = sending_arg ? arg_r : cmd_r;
  assign parity_bit  = ~^cur_byte;
  assign edge_nxt    = (state == S_START) ? 4'd1 : edge_cnt + 4'd1;
  assign timeout     = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign inhibit_end = (cnt == CNT_W'(INHIBIT_CYCLES - 1));

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state and transaction events; an rxValid or clock edge always beats a timeout
  always_comb begin
    state_nxt = state;
    take_sys  = 1'b0;
    take_led  = 1'b0;
    go_arg    = 1'b0;
    go_retry  = 1'b0;
    done_c    = 1'b0;
    err_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if (sysReq) begin
          take_sys  = 1'b1;
          state_nxt = S_INHIBIT;
        end else if (ledReq) begin
          take_led  = 1'b1;
          state_nxt = S_INHIBIT;
        end
      end
      S_INHIBIT: if (inhibit_end) state_nxt = S_START;
      S_START: begin
        if (fall)         state_nxt = S_TXBIT;
        else if (timeout) err_c     = 1'b1;
      end
      S_TXBIT: begin
        if (fall) begin
          if (edge_nxt == 4'd10) state_nxt = S_WAITACK;
        end else if (timeout) err_c = 1'b1;
      end
      S_WAITACK: begin
        if (fall) begin
          if (!dat_s) state_nxt = S_WAITRESP;
          else        err_c     = 1'b1;
        end else if (timeout) err_c = 1'b1;
      end
      S_WAITRESP: begin
        if (rxValid) begin
          case (rxByte)
            8'hFA: begin
              if (!sending_arg && has_arg_r) begin
                go_arg    = 1'b1;
                state_nxt = S_INHIBIT;
              end else if (cmd_r == 8'hFF) state_nxt = S_WAITBAT;
              else done_c = 1'b1;
            end
            8'hFE: begin
              if (retry < RETRY_W'(MAX_RETRY)) begin
                go_retry  = 1'b1;
                state_nxt = S_INHIBIT;
              end else err_c = 1'b1;
            end
            default: err_c = 1'b1;
          endcase
        end else if (timeout) err_c = 1'b1;
      end
      S_WAITBAT: begin
        if (rxValid) begin
          if (rxByte == 8'hAA) done_c = 1'b1;
          else                 err_c  = 1'b1;
        end else if (timeout) err_c = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (done_c || err_c) state_nxt = S_IDLE;
  end

  // Next values of the registered outputs; data line holds between device clock edges
  always_comb begin
    clk_oe_d = (state_nxt == S_INHIBIT);
    busy_d   = (state_nxt != S_IDLE);
    block_d  = (state_nxt != S_IDLE) || (state != S_IDLE);
    dat_oe_d = 1'b0;
    case (state_nxt)
      S_START: dat_oe_d = 1'b1;
      S_TXBIT: begin
        if (!fall)                  dat_oe_d = ps2DatOe;
        else if (edge_nxt == 4'd9)  dat_oe_d = ~parity_bit;
        else                        dat_oe_d = ~cur_byte[3'(edge_nxt - 4'd1)];
      end
      default: dat_oe_d = 1'b0;
    endcase
  end

  // Pad synchronisers, counters, captured request and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync    <= 2'b11;
      dat_sync    <= 2'b11;
      clk_prev    <= 1'b1;
      cnt         <= '0;
      edge_cnt    <= '0;
      retry       <= '0;
      sending_arg <= 1'b0;
      has_arg_r   <= 1'b0;
      cmd_r       <= '0;
      arg_r       <= '0;
      ps2ClkOe    <= 1'b0;
      ps2DatOe    <= 1'b0;
      sysGrant    <= 1'b0;
      ledGrant    <= 1'b0;
      rxBlock     <= 1'b0;
      busy        <= 1'b0;
      cmdDone     <= 1'b0;
      cmdError    <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DAT};
      clk_prev <= clk_sync[1];
      // Our own inhibit pulls the clock low, so edges only count as progress outside INHIBIT
      if (state_nxt != state || state == S_IDLE || (fall && state != S_INHIBIT)) cnt <= '0;
      else                                                                         cnt <= cnt + CNT_W'(1);
      if (fall && (state == S_START || state == S_TXBIT)) edge_cnt <= edge_nxt;
      if (take_sys) begin
        cmd_r     <= sysCmd;
        arg_r     <= sysArg;
        has_arg_r <= sysHasArg;
      end else if (take_led) begin
        cmd_r     <= 8'hED;
        arg_r     <= {5'b0, ledMask};
        has_arg_r <= 1'b1;
      end
      if (take_sys || take_led) begin
        retry       <= '0;
        sending_arg <= 1'b0;
      end else if (go_arg) begin
        retry       <= '0;
        sending_arg <= 1'b1;
      end else if (go_retry) begin
        retry <= retry + RETRY_W'(1);
      end
      ps2ClkOe <= clk_oe_d;
      ps2DatOe <= dat_oe_d;
      sysGrant <= take_sys;
      ledGrant <= take_led;
      rxBlock  <= block_d;
      busy     <= busy_d;
      cmdDone  <= done_c;
      cmdError <= err_c;
    end
  end

endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
// Bench for ps2_host_cmd_ctrl: behavioural PS/2 device on wired-AND lines, expected
// wire bytes held in a scoreboard queue and popped as each byte is clocked out.
module tb_ps2_host_cmd_ctrl;

  localparam int unsigned INH  = 20;
  localparam int unsigned TMO  = 300;
  localparam int unsigned MAXR = 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic       ps2ClkOe, ps2DatOe;
  logic       sysReq, sysHasArg, ledReq, rxValid;
  logic [7:0] sysCmd, sysArg, rxByte;
  logic [2:0] ledMask;
  logic       sysGrant, ledGrant, rxBlock, busy, cmdDone, cmdError;
  logic       dev_clk = 1'b1, dev_dat = 1'b1;
  logic       clk_line, dat_line;

  int n_checks = 0, n_errors = 0;
  int n_sysg = 0, n_ledg = 0, n_done = 0, n_err = 0, block_viol = 0;
  logic [7:0] exp_q[$];

  assign clk_line = dev_clk & ~ps2ClkOe;
  assign dat_line = dev_dat & ~ps2DatOe;

  always #5 clk = ~clk;

  ps2_host_cmd_ctrl #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .resetn(resetn), .PS2_CLK(clk_line), .PS2_DAT(dat_line),
    .ps2ClkOe(ps2ClkOe), .ps2DatOe(ps2DatOe),
    .sysReq(sysReq), .sysCmd(sysCmd), .sysHasArg(sysHasArg), .sysArg(sysArg),
    .ledReq(ledReq), .ledMask(ledMask), .sysGrant(sysGrant), .ledGrant(ledGrant),
    .rxByte(rxByte), .rxValid(rxValid), .rxBlock(rxBlock), .busy(busy),
    .cmdDone(cmdDone), .cmdError(cmdError)
  );

  always @(negedge clk) begin
    if (sysGrant) n_sysg <= n_sysg + 1;
    if (ledGrant) n_ledg <= n_ledg + 1;
    if (cmdDone)  n_done <= n_done + 1;
    if (cmdError) n_err  <= n_err + 1;
    if ((busy || cmdDone || cmdError) && !rxBlock) block_viol <= block_viol + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got hung simulation, expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_grant(input logic led, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (led ? ledGrant : sysGrant) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_end(output int kind);
    kind = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmdDone) begin kind = 1; break; end
      if (cmdError) begin kind = 2; break; end
    end
  endtask

  // Device side: wait for inhibit + start, then clock 11 bits, ACK on the 11th
  task automatic dev_xfer(input int abort_edge, output logic [7:0] b, output logic par,
                          output logic stp, output logic got);
    int n;
    logic [11:1] bits;
    got = 1'b0; b = '0; par = 1'b0; stp = 1'b0; bits = '0; n = 0;
    while (ps2ClkOe !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    while (!(ps2ClkOe === 1'b0 && ps2DatOe === 1'b1) && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) return;
    got = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 1; i <= 11; i++) begin
      dev_clk = 1'b0;
      repeat (8) @(negedge clk);
      if (i == abort_edge) return;
      bits[i] = dat_line;
      dev_clk = 1'b1;
      repeat (8) @(negedge clk);
      if (i == 10) dev_dat = 1'b0;
    end
    dev_dat = 1'b1;
    b   = bits[8:1];
    par = bits[9];
    stp = bits[10];
  endtask

  task automatic xfer_check(input string tag);
    logic [7:0] b, e;
    logic p, s, g;
    dev_xfer(0, b, p, s, g);
    check_eq({tag, "_start"}, 32'(g), 32'd1);
    if (g) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check_eq({tag, "_byte"}, 32'(b), 32'(e));
      check_eq({tag, "_par"}, 32'(p), 32'(~^e));
      check_eq({tag, "_stop"}, 32'(s), 32'd1);
      check_eq({tag, "_acked"}, 32'({busy, cmdError}), 32'b10);
    end
  endtask

  task automatic dev_resp(input logic [7:0] b);
    repeat (10) @(negedge clk);
    rxByte  = b;
    rxValid = 1'b1;
    @(posedge clk);
    #1 rxValid = 1'b0;
  endtask

  initial begin
    logic ok, g, p, s;
    logic [7:0] b;
    int kind, k, prev, prev_done, prev_err;

    resetn = 1'b0; sysReq = 1'b0; sysCmd = '0; sysHasArg = 1'b0; sysArg = '0;
    ledReq = 1'b0; ledMask = '0; rxByte = '0; rxValid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", 32'({ps2ClkOe, ps2DatOe, sysGrant, ledGrant, rxBlock, busy, cmdDone, cmdError}), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // LED update: 0xED then 0x05; a stray device byte during inhibit is ignored
    exp_q.push_back(8'hED); exp_q.push_back(8'h05);
    ledMask = 3'b101; ledReq = 1'b1;
    wait_grant(1'b1, ok);
    check_eq("t1_grant", 32'(ok), 32'd1);
    ledReq = 1'b0;
    check_eq("t1_busy_block", 32'({busy, rxBlock}), 32'b11);
    rxByte = 8'hFE; rxValid = 1'b1;
    @(negedge clk);
    rxValid = 1'b0;
    xfer_check("t1_cmd");
    dev_resp(8'hFA);
    xfer_check("t1_arg");
    dev_resp(8'hFA);
    wait_end(kind);
    check_eq("t1_end", 32'(kind), 32'd1);
    repeat (2) @(negedge clk);
    #1;
    check_eq("t1_ledg_cnt", 32'(n_ledg), 32'd1);
    check_eq("t1_done_cnt", 32'(n_done), 32'd1);
    check_eq("t1_idle", 32'({busy, rxBlock}), 32'b00);

    // Simultaneous requests: system first, LED after system completes
    sysCmd = 8'hF4; sysHasArg = 1'b0; ledMask = 3'b010;
    exp_q.push_back(8'hF4); exp_q.push_back(8'hED); exp_q.push_back(8'h02);
    sysReq = 1'b1; ledReq = 1'b1;
    @(negedge clk);
    check_eq("t2_first", 32'({sysGrant, ledGrant}), 32'b10);
    sysReq = 1'b0;
    xfer_check("t2_sys");
    prev = n_ledg;
    dev_resp(8'hFA);
    wait_end(kind);
    check_eq("t2_sys_end", 32'(kind), 32'd1);
    check_eq("t2_led_held", 32'(ledGrant), 32'd0);
    wait_grant(1'b1, ok);
    check_eq("t2_led_grant", 32'(ok), 32'd1);
    ledReq = 1'b0;
    #1;
    check_eq("t2_ledg_cnt", 32'(n_ledg), 32'(prev + 1));
    xfer_check("t2_led_cmd");
    dev_resp(8'hFA);
    xfer_check("t2_led_arg");
    dev_resp(8'hFA);
    wait_end(kind);
    check_eq("t2_led_end", 32'(kind), 32'd1);

    // Reset command: done only after the BAT byte 0xAA
    sysCmd = 8'hFF; exp_q.push_back(8'hFF);
    sysReq = 1'b1;
    wait_grant(1'b0, ok);
    check_eq("t3_grant", 32'(ok), 32'd1);
    sysReq = 1'b0;
    xfer_check("t3_cmd");
    dev_resp(8'hFA);
    repeat (30) @(negedge clk);
    check_eq("t3_wait_bat", 32'({busy, rxBlock, cmdDone}), 32'b110);
    dev_resp(8'hAA);
    wait_end(kind);
    check_eq("t3_end", 32'(kind), 32'd1);
    check_eq("t3_block_at_done", 32'(rxBlock), 32'd1);

    // Three resend requests with two retries allowed
    sysCmd = 8'hF5;
    repeat (3) exp_q.push_back(8'hF5);
    sysReq = 1'b1;
    wait_grant(1'b0, ok);
    sysReq = 1'b0;
    for (int r = 0; r < 3; r++) begin
      xfer_check($sformatf("t4_try%0d", r));
      dev_resp(8'hFE);
    end
    wait_end(kind);
    check_eq("t4_end", 32'(kind), 32'd2);
    #1;
    check_eq("t4_err_cnt", 32'(n_err), 32'd1);

    // Silent device: error exactly TIMEOUT cycles after the clock is released
    sysCmd = 8'hF4;
    sysReq = 1'b1;
    wait_grant(1'b0, ok);
    sysReq = 1'b0;
    k = 0;
    while (ps2ClkOe !== 1'b0 && k < 100) begin @(negedge clk); k++; end
    k = 0;
    while (!cmdError && k < int'(TMO) + 50) begin @(negedge clk); k++; end
    check_eq("t5_tmo_cycles", 32'(k), 32'(TMO));
    check_eq("t5_lines", 32'({ps2ClkOe, ps2DatOe, busy}), 32'b000);

    // Async reset in the middle of bit 5, then a clean LED transaction
    sysCmd = 8'hEE;
    sysReq = 1'b1;
    wait_grant(1'b0, ok);
    sysReq = 1'b0;
    dev_xfer(5, b, p, s, g);
    check_eq("t6_started", 32'(g), 32'd1);
    check_eq("t6_mid", 32'({busy, ps2DatOe}), 32'b11);
    prev_done = n_done; prev_err = n_err;
    #2 resetn = 1'b0;
    #1;
    check_eq("t6_async_rst", 32'({ps2ClkOe, ps2DatOe, sysGrant, ledGrant, rxBlock, busy, cmdDone, cmdError}), 32'd0);
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check_eq("t6_no_pulse", 32'({n_done - prev_done, n_err - prev_err}), 32'd0);
    exp_q.push_back(8'hED); exp_q.push_back(8'h03);
    ledMask = 3'b011; ledReq = 1'b1;
    wait_grant(1'b1, ok);
    check_eq("t6_grant", 32'(ok), 32'd1);
    ledReq = 1'b0;
    xfer_check("t6_cmd");
    dev_resp(8'hFA);
    xfer_check("t6_arg");
    dev_resp(8'hFA);
    wait_end(kind);
    check_eq("t6_end", 32'(kind), 32'd1);

    repeat (2) @(negedge clk);
    #1;
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    check_eq("block_viol", 32'(block_viol), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
